data_cache_control: RTL
=======================

// Module: data_cache_control
// PURPOSE
//  Sequencing FSM for the set-associative data cache datapath. It drives every mux select and
//  array load strobe, arbitrates hit, writeback and fill, and handshakes with the CPU and pmem.
//  Sits beside the dcache datapath; consumes hit/read_dirty, emits dcache_* enum selects.
// PARAMETERS
//  PERF_CNT_WIDTH  32  width of each performance counter (used only with DCACHE_PERF_CNT_EN)
// PORTS
//  clk                 in   1   sole clock, all state on rising edge
//  rst                 in   1   asynchronous, active-low reset
//  mem_read            in   1   CPU read request, held until mem_resp
//  mem_write           in   1   CPU write request, held until mem_resp
//  hit                 in   1   datapath tag match (valid & tag equal)
//  read_dirty          in   1   dirty bit of LRU way
//  pmem_resp           in   1   pmem completes current read/write
//  pmem_read           out  1   pmem line read strobe
//  pmem_write          out  1   pmem line write strobe
//  waymux_sel          out  enum dcache_waymux::waymux_sel_t
//  respmux_sel         out  enum dcache_respmux::respmux_sel_t
//  mamux_sel           out  enum dcache_mamux::mamux_sel_t
//  wdata_mux_sel       out  enum dcache_dloadmux::data_wdata_mux_sel_t
//  wren_mux_sel        out  enum dcache_dloadmux::data_wren_mux_sel_t
//  hitmux_sel          out  enum dcache_hitmux::hitmux_t (gates CPU mem_resp)
//  dirty_wren_mux_sel  out  enum dcache_dirtymux::dirty_wren_mux_sel_t
//  lru_wdata_mux_sel   out  enum dcache_lrumux::lru_wdata_mux_sel_t
//  load_tag/load_valid/load_data/load_dirty/load_lru  out 1 each  array write strobes
//  dirty_wdata         out  1   value written to dirty array
//  hit_count/miss_count/wb_count  out PERF_CNT_WIDTH  performance counters
// BEHAVIOUR
//  States: IDLE, CHECK, WRITEBACK, FETCH. Outputs are Moore/Mealy combinational from state+inputs.
//  Default, every state: all strobes 0, hitmux force_zero, waymux wayhit, respmux waymux_out,
//   mamux cpu, wdata from_cpu, wren as_hit, dirty way_hit, lru inv_hit, dirty_wdata 0.
//  Reset: state=IDLE, counters=0; outputs take the defaults immediately (async), pmem strobes low.
//  IDLE: mem_read|mem_write -> CHECK next cycle (one cycle for array read).
//  CHECK, hit: hitmux as_hit (mem_resp=1 this cycle), load_lru=1, lru inv_hit.
//   write hit additionally: load_data=1 (as_hit, from_cpu), load_dirty=1, dirty_wdata=1. -> IDLE.
//   Hit latency: 2 cycles from request to mem_resp.
//  CHECK, miss: read_dirty=1 -> WRITEBACK; else -> FETCH. No CPU resp.
//  WRITEBACK: pmem_write=1, waymux waylru, mamux waylru; hold until pmem_resp -> FETCH.
//  FETCH: pmem_read=1, mamux cpu. On pmem_resp, same cycle: load_tag=load_valid=load_data=1,
//   wren as_lru, load_dirty=1 with dirty way_lru, dirty_wdata=mem_write,
//   wdata from_mem (read) / mem_mask_cpu (write), respmux pmem_read, hitmux force_one,
//   load_lru=1 with inv_lru; -> IDLE.
//  Both mem_read and mem_write high: treated as write. Request deassert mid-miss: miss finishes,
//   line filled, mem_resp still pulses (CPU contract forbids; fill keeps arrays consistent).
//  pmem_read and pmem_write never high together; each stays high until its pmem_resp.
//  mem_resp is a single-cycle pulse per request; IDLE always separates two responses.
//  Reset asserted mid-WRITEBACK/FETCH: abandon, IDLE, no array strobes; pmem tolerates the drop.
// CONFIGURATION
//  DCACHE_PERF_CNT_EN defined: hit_count +1 on CHECK&hit, miss_count +1 on CHECK&~hit,
//   wb_count +1 on WRITEBACK&pmem_resp; each saturates at all-ones, never wraps.
//  Undefined: counter registers not built; count ports tied to 0.
// TESTING
//  Read hit: mem_read=1, hit=1 in CHECK -> mem_resp at cycle 2, load_lru=1, no pmem traffic.
//  Write hit: mem_write=1, hit=1 -> load_data, load_dirty, dirty_wdata=1, wren as_hit.
//  Clean read miss: hit=0, read_dirty=0, pmem_resp after 5 cycles -> pmem_read 5 cycles,
//   fill strobes + force_one in cycle of pmem_resp, dirty_wdata=0.
//  Dirty write miss: read_dirty=1 -> pmem_write (mamux waylru) until resp, then pmem_read,
//   fill with mem_mask_cpu, dirty_wdata=1; wb_count=1 with DCACHE_PERF_CNT_EN.
//  Reset (rst=0) during FETCH -> pmem_read drops same cycle, state IDLE, no load strobes.
//  Counter saturation with PERF_CNT_WIDTH=4: 17 hits -> hit_count holds 15.

Source files
------------

// File: rtl/data_cache_control_if.sv
// Select encodings and controller/datapath bus for the data cache sequencer.
// The package holds the mux select enums shared by controller, datapath and bench;
// the interface groups the request/response, pmem and datapath control signals.

package data_cache_control_pkg;
   typedef enum logic {WAYMUX_WAYHIT = 1'b0, WAYMUX_WAYLRU = 1'b1} waymux_sel_t;
   typedef enum logic {RESPMUX_WAYMUX_OUT = 1'b0, RESPMUX_PMEM_READ = 1'b1} respmux_sel_t;
   typedef enum logic {MAMUX_CPU = 1'b0, MAMUX_WAYLRU = 1'b1} mamux_sel_t;
   typedef enum logic [1:0] {
      WDATA_FROM_CPU     = 2'd0,
      WDATA_FROM_MEM     = 2'd1,
      WDATA_MEM_MASK_CPU = 2'd2
   } data_wdata_mux_sel_t;
   typedef enum logic {WREN_AS_HIT = 1'b0, WREN_AS_LRU = 1'b1} data_wren_mux_sel_t;
   // hitmux gates the CPU response: force_zero = no resp, as_hit = resp on hit, force_one = resp
   typedef enum logic [1:0] {
      HITMUX_FORCE_ZERO = 2'd0,
      HITMUX_AS_HIT     = 2'd1,
      HITMUX_FORCE_ONE  = 2'd2
   } hitmux_t;
   typedef enum logic {DIRTY_WAY_HIT = 1'b0, DIRTY_WAY_LRU = 1'b1} dirty_wren_mux_sel_t;
   typedef enum logic {LRU_INV_HIT = 1'b0, LRU_INV_LRU = 1'b1} lru_wdata_mux_sel_t;
endpackage

interface data_cache_control_if;
   import data_cache_control_pkg::*;

   logic                mem_read;
   logic                mem_write;
   logic                hit;
   logic                read_dirty;
   logic                pmem_resp;
   logic                pmem_read;
   logic                pmem_write;
   waymux_sel_t         waymux_sel;
   respmux_sel_t        respmux_sel;
   mamux_sel_t          mamux_sel;
   data_wdata_mux_sel_t wdata_mux_sel;
   data_wren_mux_sel_t  wren_mux_sel;
   hitmux_t             hitmux_sel;
   dirty_wren_mux_sel_t dirty_wren_mux_sel;
   lru_wdata_mux_sel_t  lru_wdata_mux_sel;
   logic                load_tag;
   logic                load_valid;
   logic                load_data;
   logic                load_dirty;
   logic                load_lru;
   logic                dirty_wdata;

   // controller side
   modport master (
      input  mem_read, mem_write, hit, read_dirty, pmem_resp,
      output pmem_read, pmem_write, waymux_sel, respmux_sel, mamux_sel,
             wdata_mux_sel, wren_mux_sel, hitmux_sel, dirty_wren_mux_sel,
             lru_wdata_mux_sel, load_tag, load_valid, load_data, load_dirty,
             load_lru, dirty_wdata
   );

   // datapath / CPU / pmem side
   modport slave (
      output mem_read, mem_write, hit, read_dirty, pmem_resp,
      input  pmem_read, pmem_write, waymux_sel, respmux_sel, mamux_sel,
             wdata_mux_sel, wren_mux_sel, hitmux_sel, dirty_wren_mux_sel,
             lru_wdata_mux_sel, load_tag, load_valid, load_data, load_dirty,
             load_lru, dirty_wdata
   );
endinterface

// File: rtl/data_cache_control.sv
// Sequencing FSM for the set-associative data cache datapath.
// Optional performance counters are built when DCACHE_PERF_CNT_EN is defined;
// otherwise the count ports are tied to zero.
//
// state     | meaning
// IDLE      | waiting for a CPU request
// CHECK     | arrays read out, resolve hit / miss
// WRITEBACK | dirty LRU line being written to pmem
// FETCH     | line being read from pmem and filled

module data_cache_control
   import data_cache_control_pkg::*;
#(
   parameter int PERF_CNT_WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   data_cache_control_if.master      bus,
   output logic [PERF_CNT_WIDTH-1:0] hit_count,
   output logic [PERF_CNT_WIDTH-1:0] miss_count,
   output logic [PERF_CNT_WIDTH-1:0] wb_count
);

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] CHECK     = 2'd1;
   localparam logic [1:0] WRITEBACK = 2'd2;
   localparam logic [1:0] FETCH     = 2'd3;

   logic [1:0] state_q, state_d;

   // next-state selection
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:      if (bus.mem_read || bus.mem_write) state_d = CHECK;
         CHECK:     if (bus.hit)             state_d = IDLE;
                    else if (bus.read_dirty) state_d = WRITEBACK;
                    else                     state_d = FETCH;
         WRITEBACK: if (bus.pmem_resp) state_d = FETCH;
         FETCH:     if (bus.pmem_resp) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   // state register; reset drops any pmem transaction in flight
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // datapath selects and array strobes from state and inputs
   always_comb begin
      bus.pmem_read          = 1'b0;
      bus.pmem_write         = 1'b0;
      bus.waymux_sel         = WAYMUX_WAYHIT;
      bus.respmux_sel        = RESPMUX_WAYMUX_OUT;
      bus.mamux_sel          = MAMUX_CPU;
      bus.wdata_mux_sel      = WDATA_FROM_CPU;
      bus.wren_mux_sel       = WREN_AS_HIT;
      bus.hitmux_sel         = HITMUX_FORCE_ZERO;
      bus.dirty_wren_mux_sel = DIRTY_WAY_HIT;
      bus.lru_wdata_mux_sel  = LRU_INV_HIT;
      bus.load_tag           = 1'b0;
      bus.load_valid         = 1'b0;
      bus.load_data          = 1'b0;
      bus.load_dirty         = 1'b0;
      bus.load_lru           = 1'b0;
      bus.dirty_wdata        = 1'b0;
      unique case (state_q)
         CHECK: begin
            if (bus.hit) begin
               bus.hitmux_sel = HITMUX_AS_HIT;
               bus.load_lru   = 1'b1;
               // write wins when both request lines are high
               if (bus.mem_write) begin
                  bus.load_data   = 1'b1;
                  bus.load_dirty  = 1'b1;
                  bus.dirty_wdata = 1'b1;
               end
            end
         end
         WRITEBACK: begin
            bus.pmem_write = 1'b1;
            bus.waymux_sel = WAYMUX_WAYLRU;
            bus.mamux_sel  = MAMUX_WAYLRU;
         end
         FETCH: begin
            bus.pmem_read = 1'b1;
            if (bus.pmem_resp) begin
               // fill completes even if the CPU dropped its request mid-miss
               bus.load_tag           = 1'b1;
               bus.load_valid         = 1'b1;
               bus.load_data          = 1'b1;
               bus.wren_mux_sel       = WREN_AS_LRU;
               bus.load_dirty         = 1'b1;
               bus.dirty_wren_mux_sel = DIRTY_WAY_LRU;
               bus.dirty_wdata        = bus.mem_write;
               bus.wdata_mux_sel      = bus.mem_write ? WDATA_MEM_MASK_CPU : WDATA_FROM_MEM;
               bus.respmux_sel        = RESPMUX_PMEM_READ;
               bus.hitmux_sel         = HITMUX_FORCE_ONE;
               bus.load_lru           = 1'b1;
               bus.lru_wdata_mux_sel  = LRU_INV_LRU;
            end
         end
         default: ;
      endcase
   end

`ifdef DCACHE_PERF_CNT_EN
   logic [PERF_CNT_WIDTH-1:0] hit_cnt_q, miss_cnt_q, wb_cnt_q;

   // saturating event counters
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
         wb_cnt_q   <= '0;
      end else begin
         if (state_q == CHECK && bus.hit && hit_cnt_q != '1)
            hit_cnt_q <= hit_cnt_q + 1'b1;
         if (state_q == CHECK && !bus.hit && miss_cnt_q != '1)
            miss_cnt_q <= miss_cnt_q + 1'b1;
         if (state_q == WRITEBACK && bus.pmem_resp && wb_cnt_q != '1)
            wb_cnt_q <= wb_cnt_q + 1'b1;
      end
   end

   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;
   assign wb_count   = wb_cnt_q;
`else
   assign hit_count  = '0;
   assign miss_count = '0;
   assign wb_count   = '0;
`endif

endmodule
